sample_batcher: RTL
===================

Name: sample_batcher

Overview:
- Front-end stage of the control-bounded filter datapath.
- Collects the per-clock M-bit control vectors into a sliding window of BATCH samples.
- Emits the whole window, with a one-cycle strobe, once every DSR accepted samples.
- Output feeds directly into the alignment delay line that lines up the lookahead and lookback FIR paths.

Parameters:
- M, 4, number of control signals per sample (bits per sample).
- BATCH, 8, window length in samples (>=1).
- DSR, 4, downsampling ratio, i.e. accepted samples between output strobes (>=1; may exceed BATCH).

Ports:
- clk, input, 1, sole clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset.
- in, input, M, current control vector.
- in_valid, input, 1, qualifies in; sample accepted at a posedge where in_valid=1.
- out, output, M*BATCH, registered window; slice out[M*(i+1)-1 : M*i] = window[i].
- out_valid, output, 1, one-cycle strobe marking a fresh batch on out.
- primed, output, 1, high once BATCH samples have been accepted since reset.

Behaviour:
- Reset (rst=0, asynchronous, takes effect without clk):
  - all window entries = 0, out = 0, out_valid = 0, primed = 0;
  - state = FILL; fill counter = 0; phase counter = 0.
  - Reset mid-batch discards all partial data; refill starts from zero on rst release.
- Accept (in_valid=1 at posedge): window[0] <= in, window[i] <= window[i-1] for i=1..BATCH-1. Oldest sample is dropped.
- in_valid=0: window, counters and state hold; out_valid <= 0.
- FSM:
  - FILL: fill counter increments per accepted sample. On the accept that makes BATCH samples total: state <= RUN, primed <= 1, out_valid <= 1, phase counter <= 0.
  - RUN: phase counter increments modulo DSR per accepted sample. When an accept wraps it from DSR-1 to 0, out_valid <= 1. No other transitions except reset.
- out_valid is registered. It is high exactly in the cycle after the triggering accept edge, and out already contains the triggering sample in window[0].
- Strobe schedule: strobes follow accepted samples number BATCH, BATCH+DSR, BATCH+2*DSR, ... counted since reset. Invalid cycles stretch the schedule; they never shift its phase.
- DSR=1: out_valid follows every accepted sample once primed.
- BATCH=1: first accept primes and strobes immediately.
- No back-pressure. Downstream must consume out in the strobe cycle. out stays stable until the next accept.
- Counter widths: $clog2(BATCH+1) for fill and $clog2(DSR)+1 for phase. Neither may wrap unintentionally; fill saturates in RUN.

Optional Feature:
- Macro BATCH_REVERSE_EN.
- Defined: output slice i carries window[BATCH-1-i], oldest sample in the LSB slice. This is the ordering used by the lookback path.
- Not defined: newest sample in the LSB slice, as above.
- Timing, out_valid and primed are identical in both builds; only the output wiring is reversed.

Decomposition:
- Shared package cb_batch_pkg:
  - typedef enum {FILL, RUN} batch_state_t;
  - width helper constants/functions for counter sizing;
  - slice-index function used by both output orderings.
- One natural sub-module: batch_phase_counter. It is a parameterised modulo-DSR counter with enable, async active-low reset and wrap pulse. It is reused by the downstream decimation logic.

Test Plan:
- M=4, BATCH=8, DSR=4, in_valid=1 continuously, in = 1,2,3,…:
  - primed and out_valid rise in the cycle after the 8th accept;
  - out = {8,7,…,1} with 1 in the MSB slice (LSB slice=8);
  - further strobes after samples 12, 16, 20.
- Same config, in_valid toggling 1,0,1,0:
  - strobes after the 8th and 12th accepted samples only;
  - out and counters unchanged during invalid cycles.
- Reset asserted mid-RUN between clock edges:
  - out, out_valid and primed go 0 immediately;
  - after release, 8 more accepts are needed before the next strobe.
- DSR=1, BATCH=3:
  - strobe after accepts 3, 4, 5, …;
  - window slides one sample per strobe.
- DSR=10, BATCH=4:
  - strobes after accepts 4, 14, 24;
  - out reflects only the last 4 samples at each strobe.
- BATCH_REVERSE_EN defined, first scenario repeated:
  - out has 1 in the LSB slice and 8 in the MSB slice;
  - strobe timing matches the non-reversed build exactly.

Source files
------------

// File: rtl/cb_batch_pkg.sv
// Shared types and sizing helpers for the control-bounded filter batching front end.
//   batch_state_t : FILL while the window is still being populated, RUN once primed.
//   fill_cnt_w    : width of a counter that must hold 0..batch inclusive.
//   phase_cnt_w   : width of the modulo-dsr phase counter.
//   slice_idx     : maps an output slice to a window entry for either output ordering.
package cb_batch_pkg;

  typedef enum logic [0:0] {FILL, RUN} batch_state_t;

  function automatic int unsigned fill_cnt_w(input int unsigned batch);
    return $clog2(batch + 1);
  endfunction

  function automatic int unsigned phase_cnt_w(input int unsigned dsr);
    return $clog2(dsr) + 1;
  endfunction

  // reverse=0: slice i carries window[i] (newest in LSB slice).
  // reverse=1: slice i carries window[batch-1-i] (oldest in LSB slice).
  function automatic int unsigned slice_idx(input int unsigned i, input int unsigned batch,
                                            input bit reverse);
    return reverse ? (batch - 1 - i) : i;
  endfunction

endpackage

// File: rtl/batch_phase_counter.sv
// Modulo-Modulo up counter with enable and a combinational wrap pulse.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count to 0
//   en_i   : advance the count by one at the next posedge
//   wrap_o : high when en_i is set and the count is at Modulo-1 (it returns to 0 next edge)
module batch_phase_counter
  import cb_batch_pkg::*;
#(
  parameter int unsigned Modulo = 4,
  parameter int unsigned Width  = phase_cnt_w(Modulo)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [Width-1:0] Last = Width'(Modulo - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_batcher.sv
// Collects M-bit control vectors into a sliding window of BATCH samples and strobes the
// whole window out once every DSR accepted samples after the window first fills.
// Ports:
//   clk       : clock, all updates on posedge
//   rst       : asynchronous active-low reset
//   in        : current M-bit control vector
//   in_valid  : sample accepted on a posedge where this is high
//   out       : registered window, M bits per slice
//   out_valid : one-cycle strobe, high the cycle after a triggering accept
//   primed    : high once BATCH samples have been accepted since reset
// Build option: define BATCH_REVERSE_EN to put the oldest sample in the LSB slice
// (lookback ordering); otherwise the newest sample sits in the LSB slice.
module sample_batcher
  import cb_batch_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned BATCH = 8,
  parameter int unsigned DSR   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     in,
  input  logic             in_valid,
  output logic [M*BATCH-1:0] out,
  output logic             out_valid,
  output logic             primed
);

  localparam int unsigned FillW = fill_cnt_w(BATCH);
  localparam logic [FillW-1:0] FillLast = FillW'(BATCH - 1);
  localparam logic [FillW-1:0] FillFull = FillW'(BATCH);

`ifdef BATCH_REVERSE_EN
  localparam bit Reverse = 1'b1;
`else
  localparam bit Reverse = 1'b0;
`endif

  batch_state_t     state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic             primed_q, primed_d;
  logic [M-1:0]     window_q [BATCH];
  logic [M-1:0]     window_d [BATCH];
  logic             phase_en;
  logic             phase_wrap;

  // Phase only runs once primed; it sits at 0 through FILL so the first RUN accept is phase 0.
  assign phase_en = (state_q == RUN) && in_valid;

  batch_phase_counter #(
    .Modulo(DSR)
  ) u_phase (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (phase_en),
    .wrap_o(phase_wrap)
  );

  always_comb begin
    window_d = window_q;
    if (in_valid) begin
      window_d[0] = in;
      for (int unsigned i = 1; i < BATCH; i++) begin
        window_d[i] = window_q[i-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (fill_q == FillLast) begin
            state_d     = RUN;
            fill_d      = FillFull;
            primed_d    = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
      end
      RUN: begin
        out_valid_d = phase_wrap;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      window_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
      window_q    <= window_d;
    end
  end

  for (genvar i = 0; i < BATCH; i++) begin : g_out
    localparam int unsigned Idx = slice_idx(i, BATCH, Reverse);
    assign out[M*i +: M] = window_q[Idx];
  end

  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule
